// File: rtl/message_receive.sv
// UART 8N1 receiver with message assembler.
// Characters from rxd are deserialized and packed MSB-first into msg. A message
// completes on TERM_CHAR or when the buffer fills.
// Optional build macro MSG_MATCH_EN: compare each completed message against
// "hello world!" and report the result on match (tied low when undefined).
module message_receive #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned MSG_BYTES    = 12,
  parameter logic [7:0]  TERM_CHAR    = 8'h21
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               SW,
  input  logic                               rxd,
  output logic [7:0]                         word,
  output logic                               byte_valid,
  output logic [8*MSG_BYTES-1:0]             msg,
  output logic [$clog2(MSG_BYTES+1)-1:0]     msg_len,
  output logic                               msg_valid,
  output logic                               frame_err,
  output logic                               match
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned LEN_W = $clog2(MSG_BYTES + 1);
  localparam int unsigned MSG_W = 8 * MSG_BYTES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_HOLD   // bad stop bit seen; wait for the line to return high
  } state_t;

  state_t             state, state_n;
  logic               rx_meta, rxs;
  logic [CNT_W-1:0]   clk_cnt, clk_cnt_n;
  logic [2:0]         bit_cnt, bit_cnt_n;
  logic [7:0]         shift, shift_n;
  logic               accept_c, ferr_c;

  logic [LEN_W-1:0]   byte_count, count_n, count_inc;
  logic [MSG_W-1:0]   msg_n;
  logic               done_c;
  logic               hello_c;

  // Two-flop synchronizer for the asynchronous serial input, preset to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Receiver state and bit-timing registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
    end
  end

  // Receiver next-state: mid-bit sampling, LSB first; SW low forces idle.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    accept_c  = 1'b0;
    ferr_c    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_n   = S_START;
          clk_cnt_n = '0;
        end
      end
      S_START: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = rxs ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_n = '0;
          shift_n   = {rxs, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            state_n   = S_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_n = '0;
          if (rxs) begin
            accept_c = 1'b1;
            state_n  = S_IDLE;
          end else begin
            ferr_c  = 1'b1;
            state_n = S_HOLD;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (rxs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (!SW) begin
      state_n   = S_IDLE;
      clk_cnt_n = '0;
      bit_cnt_n = '0;
      accept_c  = 1'b0;
      ferr_c    = 1'b0;
    end
  end

  // Message assembly: place accepted byte at slot byte_count from the MSB end.
  always_comb begin
    msg_n     = msg;
    count_n   = byte_count;
    count_inc = byte_count + LEN_W'(1);
    done_c    = 1'b0;
    if (accept_c) begin
      if (byte_count == '0) msg_n = '0;
      for (int i = 0; i < int'(MSG_BYTES); i++) begin
        if (byte_count == LEN_W'(i)) msg_n[MSG_W-8-8*i +: 8] = shift;
      end
      if (shift == TERM_CHAR || count_inc == LEN_W'(MSG_BYTES)) begin
        done_c  = 1'b1;
        count_n = '0;
      end else begin
        count_n = count_inc;
      end
    end
    if (ferr_c || !SW) count_n = '0;
  end

`ifdef MSG_MATCH_EN
  localparam logic [95:0] HELLO = 96'h68656c6c6f20776f726c6421;
  if (MSG_BYTES == 12) begin : g_cmp
    assign hello_c = (msg_n[95:0] == HELLO);
  end else begin : g_nocmp
    assign hello_c = 1'b0;
  end
`else
  assign hello_c = 1'b0;
`endif

  // Registered outputs and message byte counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_count <= '0;
      word       <= '0;
      byte_valid <= 1'b0;
      msg        <= '0;
      msg_len    <= '0;
      msg_valid  <= 1'b0;
      frame_err  <= 1'b0;
      match      <= 1'b0;
    end else begin
      byte_count <= count_n;
      byte_valid <= accept_c;
      msg_valid  <= done_c;
      frame_err  <= ferr_c;
      msg        <= msg_n;
      if (accept_c) word <= shift;
      if (done_c) begin
        msg_len <= count_inc;
        match   <= hello_c;
      end
    end
  end

endmodule

// File: doc/message_receive.md
Name: message_receive

Overview:
- UART 8N1 receiver plus message assembler; the receive-side counterpart of the message transmit path.
- Deserializes characters from rxd and packs them into a message buffer.
- Flags a complete message on the terminator character or when the buffer is full.
- Optionally compares the completed message against the canned string "hello world!".

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per UART bit (100 MHz / 9600 baud); must be >= 4.
- MSG_BYTES, 12, message buffer depth in bytes.
- TERM_CHAR, 8'h21, terminator character ('!'); it is stored as the last byte of the message.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- SW  in  1  receive enable; 1 = receive, 0 = hold idle.
- rxd  in  1  UART serial input; idle high; asynchronous to clk.
- word  out  8  last correctly framed character.
- byte_valid  out  1  one-cycle pulse when word updates.
- msg  out  8*MSG_BYTES  message buffer; first character in the MSB byte, left-aligned.
- msg_len  out  $clog2(MSG_BYTES+1)  byte count of the last completed message.
- msg_valid  out  1  one-cycle pulse when a message completes.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- match  out  1  1 when the last completed message equals "hello world!".

Behaviour:
- Reset (rst=0, async) clears word, msg, msg_len, byte_count and all pulse outputs. match=0, FSM=IDLE, bit counters=0. The rxd synchronizer is preset to 1.
- rxd passes through a 2-flop synchronizer; all FSM references use the synchronized value (rxs).
- FSM states:
  - IDLE: on rxs=0 (falling edge of idle-high line) -> START, clear the clock counter.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample rxs. If 0 -> DATA; if 1 (glitch) -> IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first, into a shift register. After the 8th sample -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - If 1: word <= data, byte_valid=1 for one cycle, byte enters the message assembler. -> IDLE.
    - If 0: frame_err=1 for one cycle, byte discarded, byte_count cleared (partial message aborted). -> IDLE only once rxs=1 (no false start on a held-low line).
- Latency: byte_valid asserts the cycle after the stop-bit sample, which is 9.5*CLKS_PER_BIT + 3 cycles after the rxd falling edge (2 synchronizer cycles + 1 register cycle).
- Message assembler, on each accepted byte:
  - Write the byte into slot byte_count, counted from the MSB end of msg; byte_count++.
  - If byte == TERM_CHAR or byte_count reaches MSG_BYTES: msg_valid=1 in the same cycle as byte_valid, msg_len <= new count, byte_count <= 0, match updated.
  - On the first byte of a new message, bytes below slot 0 are zeroed so stale data never persists.
  - msg holds its contents between messages.
- Terminator arriving exactly at byte MSG_BYTES: one msg_valid only, msg_len = MSG_BYTES.
- SW=0: FSM forced to IDLE and byte_count cleared, synchronously. word, msg, msg_len and match hold. Pulses stay 0.
- SW falling mid-frame: the byte is dropped; no frame_err.
- Back-to-back frames (start bit immediately after stop) are received without loss.
- All counters saturate/clear explicitly; no wrap-around is relied upon.

Optional Feature:
- Macro: MSG_MATCH_EN.
- Defined: a 96-bit comparator checks msg against "hello world!" in the msg_valid cycle. match is registered and holds until the next msg_valid. Comparison is only meaningful when MSG_BYTES = 12; otherwise match=0.
- Undefined: comparator omitted; match tied to 0.

Test Plan (CLKS_PER_BIT=16 for simulation):
- Send 0x55, then 0xA3, with a correct stop bit -> word=0x55 then 0xA3, one byte_valid each, frame_err=0.
- Send "hello world!" back-to-back -> single msg_valid on '!', msg_len=12, msg="hello world!". match=1 with MSG_MATCH_EN, 0 without.
- Send "hi!" -> msg_valid, msg_len=3, msg[95:72]="hi!", lower 72 bits = 0, match=0.
- Send 0x41 with stop bit=0 -> frame_err pulse, no byte_valid. Next send "ok!" -> msg_len=3 (partial count was cleared).
- 4-cycle low glitch on rxd -> no byte_valid and no frame_err. Then 14 non-'!' bytes -> msg_valid after byte 12 (msg_len=12), then a new message starts with bytes 13-14.
- Assert rst=0 asynchronously mid-DATA, then SW=0 during a frame -> all outputs cleared immediately on reset. The frame during SW=0 is dropped, with no pulses.
